// File: rtl/adder_8_bit_with_overflow_if.sv
// Operand/result bundle for the registered adder slice.
// The master drives operands and observes results; the slave is the adder.
interface adder_8_bit_with_overflow_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output a,
    output b,
    input  sum,
    input  c_out,
    input  overflow
  );

  modport slave (
    input  a,
    input  b,
    output sum,
    output c_out,
    output overflow
  );
endinterface

// File: rtl/adder_8_bit_with_overflow.sv
// Registered ripple-carry adder producing the sum, the unsigned carry-out and
// the signed overflow flag one clock after the operands are presented.
module adder_8_bit_with_overflow #(
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  adder_8_bit_with_overflow_if.slave    bus
);

  // Carry chain: w_carry[i] is the carry into bit i; bit 0 has no carry-in.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_overflow;

  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             r_overflow;

  assign w_carry[0] = 1'b0;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_fa
      logic w_p;
      // Propagate term shared by the sum and carry equations of this cell.
      assign w_p            = bus.a[gi] ^ bus.b[gi];
      assign w_sum[gi]      = w_p ^ w_carry[gi];
      assign w_carry[gi+1]  = (bus.a[gi] & bus.b[gi]) | (w_carry[gi] & w_p);
    end
  endgenerate

  // Signed overflow is the disagreement between the carries into and out of the MSB.
  assign w_overflow = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  // Output register stage; reset wins over loading a new result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum      <= {WIDTH{1'b0}};
      r_c_out    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_sum      <= w_sum;
      r_c_out    <= w_carry[WIDTH];
      r_overflow <= w_overflow;
    end
  end

  assign bus.sum      = r_sum;
  assign bus.c_out    = r_c_out;
  assign bus.overflow = r_overflow;

endmodule

// File: tb/tb_adder_8_bit_with_overflow.sv
// Directed and exhaustive self-checking bench for the registered 8-bit adder.
module tb_adder_8_bit_with_overflow;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;

  int n_checks;
  int n_fails;

  adder_8_bit_with_overflow_if #(.WIDTH(WIDTH)) bus ();

  adder_8_bit_with_overflow #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands/reset away from the edge, then settle just after the edge.
  task automatic step(input logic [7:0] av, input logic [7:0] bv, input logic rv);
    @(negedge clk);
    bus.a = av;
    bus.b = bv;
    rst   = rv;
    @(posedge clk);
    #1;
  endtask

  // Compare all three outputs against expected values.
  task automatic check(input string tag, input logic [7:0] es, input logic ec, input logic eo);
    n_checks = n_checks + 1;
    assert (bus.sum === es) else begin
      n_fails = n_fails + 1;
      $error("FAIL %s sum: got %02h expected %02h", tag, bus.sum, es);
    end
    n_checks = n_checks + 1;
    assert (bus.c_out === ec) else begin
      n_fails = n_fails + 1;
      $error("FAIL %s c_out: got %0b expected %0b", tag, bus.c_out, ec);
    end
    n_checks = n_checks + 1;
    assert (bus.overflow === eo) else begin
      n_fails = n_fails + 1;
      $error("FAIL %s overflow: got %0b expected %0b", tag, bus.overflow, eo);
    end
  endtask

  initial begin
    logic [8:0] full;
    logic [7:0] xa;
    logic [7:0] xb;
    logic       xo;
    n_checks = 0;
    n_fails  = 0;
    bus.a    = 8'h00;
    bus.b    = 8'h00;
    rst      = 1'b1;

    // Reset held for two edges with nonzero operands.
    step(8'hFF, 8'hFF, 1'b1);
    check("reset_edge1", 8'h00, 1'b0, 1'b0);
    step(8'hFF, 8'hFF, 1'b1);
    check("reset_edge2", 8'h00, 1'b0, 1'b0);
    step(8'hFF, 8'hFF, 1'b0);
    check("reset_release", 8'hFE, 1'b1, 1'b0);

    // Flag cases.
    step(8'h05, 8'h03, 1'b0);
    check("5_plus_3", 8'h08, 1'b0, 1'b0);
    step(8'h7F, 8'h01, 1'b0);
    check("7f_plus_01", 8'h80, 1'b0, 1'b1);
    step(8'hFF, 8'h01, 1'b0);
    check("ff_plus_01", 8'h00, 1'b1, 1'b0);
    step(8'h80, 8'h80, 1'b0);
    check("80_plus_80", 8'h00, 1'b1, 1'b1);
    step(8'h80, 8'hFF, 1'b0);
    check("80_plus_ff", 8'h7F, 1'b1, 1'b1);

    // Back-to-back results on consecutive edges.
    step(8'h10, 8'h20, 1'b0);
    check("b2b_first", 8'h30, 1'b0, 1'b0);
    step(8'h7F, 8'h7F, 1'b0);
    check("b2b_second", 8'hFE, 1'b0, 1'b1);

    // Mid-stream reset for a single edge, then resume with current operands.
    step(8'h11, 8'h22, 1'b0);
    check("mid_before", 8'h33, 1'b0, 1'b0);
    step(8'h40, 8'h40, 1'b1);
    check("mid_reset", 8'h00, 1'b0, 1'b0);
    step(8'h40, 8'h40, 1'b0);
    check("mid_resume", 8'h80, 1'b0, 1'b1);

    // Exhaustive sweep against a reference model.
    for (int i = 0; i < 65536; i++) begin
      xa   = i[15:8];
      xb   = i[7:0];
      full = {1'b0, xa} + {1'b0, xb};
      xo   = (xa[7] == xb[7]) && (full[7] != xa[7]);
      step(xa, xb, 1'b0);
      check("exhaustive", full[7:0], full[8], xo);
    end

    $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
    $finish;
  end

endmodule
